// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion and common widths.
// Conversions work on a zero-extended 32-bit vector so any pointer width up to 32 can use them.
package fifo_pkg;

  localparam int unsigned RD_COUNT_W = 16;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned k = 1; k < 32; k++) begin
      b[31-k] = b[32-k] ^ g[31-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// One-entry valid/ready output stage: load takes priority, otherwise accept clears valid.
module fifo_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fifo_rd_port.sv
// FIFO read port: read pointer, empty flag and memory address, feeding a registered FWFT output stage.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDRSIZE:0]     rq2_wptr,
  input  logic [DATASIZE-1:0]   mem_rdata,
  output logic [ADDRSIZE-1:0]   raddr,
  output logic [ADDRSIZE:0]     rptr,
  output logic                  rempty,
  output logic [ADDRSIZE:0]     rcount,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATASIZE-1:0]   m_data,
  output logic [15:0]           rd_count
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;

  logic [PTR_W-1:0]      rbin_q, rbin_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic                  rempty_q, rempty_d;
  logic [RD_COUNT_W-1:0] rd_count_q, rd_count_d;
  logic                  mem_pop;
  logic                  accept;

  assign mem_pop = !rempty_q && (!m_valid || m_ready);
  assign accept  = m_valid && m_ready;

  // Empty is judged on the post-pop pointer so the last word never triggers an extra read.
  always_comb begin
    rbin_d     = rbin_q + PTR_W'(mem_pop);
    rptr_d     = PTR_W'(bin2gray(32'(rbin_d)));
    rempty_d   = (rptr_d == rq2_wptr);
    rd_count_d = rd_count_q + RD_COUNT_W'(accept);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      rd_count_q <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      rd_count_q <= rd_count_d;
    end
  end

  fifo_out_reg #(
    .WIDTH (DATASIZE)
  ) u_out_reg (
    .clk     (rclk),
    .rst     (rrst),
    .load_i  (mem_pop),
    .data_i  (mem_rdata),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  assign raddr    = rbin_q[ADDRSIZE-1:0];
  assign rptr     = rptr_q;
  assign rempty   = rempty_q;
  assign rcount   = PTR_W'(gray2bin(32'(rq2_wptr))) - rbin_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port with a behavioural combinational memory.
module tb_fifo_rd_port;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [7:0] mem_rdata;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rcount;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [15:0] rd_count;

  logic [7:0] mem [16];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 rclk = ~rclk;

  assign mem_rdata = mem[raddr];

  fifo_rd_port #(
    .DATASIZE (8),
    .ADDRSIZE (4)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rq2_wptr  (rq2_wptr),
    .mem_rdata (mem_rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rcount    (rcount),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .rd_count  (rd_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    rq2_wptr = '0;
    m_ready = 1'b0;
    tick();
    tick();
    rrst = 1'b0;
  endtask

  initial begin
    rrst = 1'b1;
    rq2_wptr = '0;
    m_ready = 1'b0;
    for (int unsigned i = 0; i < 16; i++) mem[i] = '0;
    @(negedge rclk);

    // Reset state
    do_reset();
    check("rst_rempty",   32'(rempty),   32'd1);
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_raddr",    32'(raddr),    32'd0);
    check("rst_rptr",     32'(rptr),     32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_rcount",   32'(rcount),   32'd0);
    check("rst_m_data",   32'(m_data),   32'd0);

    // Single word: two-cycle latency to the output stage
    mem[0] = 8'hA5;
    rq2_wptr = 5'b00001;
    tick();
    check("sw_rempty_e1",  32'(rempty),  32'd0);
    check("sw_valid_e1",   32'(m_valid), 32'd0);
    tick();
    check("sw_valid_e2",   32'(m_valid), 32'd1);
    check("sw_data_e2",    32'(m_data),  32'hA5);
    check("sw_raddr_e2",   32'(raddr),   32'd1);
    check("sw_rempty_e2",  32'(rempty),  32'd1);
    check("sw_rptr_e2",    32'(rptr),    32'b00001);
    check("sw_rcount_e2",  32'(rcount),  32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("sw_valid_acc",  32'(m_valid),  32'd0);
    check("sw_rdcnt_acc",  32'(rd_count), 32'd1);

    // Back-pressure then streaming drain
    do_reset();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    rq2_wptr = 5'b00010;
    for (int unsigned i = 0; i < 5; i++) tick();
    check("bp_valid",  32'(m_valid), 32'd1);
    check("bp_data",   32'(m_data),  32'h11);
    check("bp_raddr",  32'(raddr),   32'd1);
    check("bp_rcount", 32'(rcount),  32'd2);
    check("bp_rempty", 32'(rempty),  32'd0);
    m_ready = 1'b1;
    tick();
    check("bp_data2",   32'(m_data),   32'h22);
    check("bp_valid2",  32'(m_valid),  32'd1);
    check("bp_rdcnt2",  32'(rd_count), 32'd1);
    tick();
    check("bp_data3",   32'(m_data),   32'h33);
    check("bp_valid3",  32'(m_valid),  32'd1);
    check("bp_rempty3", 32'(rempty),   32'd1);
    tick();
    check("bp_valid_end", 32'(m_valid),  32'd0);
    check("bp_rdcnt_end", 32'(rd_count), 32'd3);
    m_ready = 1'b0;

    // Reset while a word is held, with ready high
    do_reset();
    rq2_wptr = 5'b00010;
    for (int unsigned i = 0; i < 3; i++) tick();
    check("mr_valid_pre", 32'(m_valid), 32'd1);
    rrst = 1'b1;
    m_ready = 1'b1;
    tick();
    check("mr_valid",  32'(m_valid),  32'd0);
    check("mr_raddr",  32'(raddr),    32'd0);
    check("mr_rptr",   32'(rptr),     32'd0);
    check("mr_rdcnt",  32'(rd_count), 32'd0);
    check("mr_rempty", 32'(rempty),   32'd1);
    check("mr_data",   32'(m_data),   32'd0);

    // Full memory and raddr wrap
    do_reset();
    for (int unsigned i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i * 3);
    rq2_wptr = 5'b11000;
    #1;
    check("full_rcount", 32'(rcount), 32'd16);
    m_ready = 1'b1;
    tick();
    check("full_rempty_e1", 32'(rempty), 32'd0);
    tick();
    for (int unsigned k = 0; k < 16; k++) begin
      check("wrap_valid", 32'(m_valid), 32'd1);
      check("wrap_data",  32'(m_data),  32'(8'(8'h40 + k * 3)));
      check("wrap_raddr", 32'(raddr),   (k + 1) % 16);
      tick();
    end
    check("wrap_valid_end", 32'(m_valid),  32'd0);
    check("wrap_rptr",      32'(rptr),     32'b11000);
    check("wrap_rempty",    32'(rempty),   32'd1);
    check("wrap_rcount",    32'(rcount),   32'd0);
    check("wrap_rdcnt",     32'(rd_count), 32'd16);

    // Idle with ready high: nothing moves
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("idle_valid", 32'(m_valid), 32'd0);
    end
    check("idle_raddr", 32'(raddr),    32'd0);
    check("idle_rptr",  32'(rptr),     32'b11000);
    check("idle_rdcnt", 32'(rd_count), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
